// File: rtl/uart_rx_stream.sv
// -----------------------------------------------------------------------------
// uart_rx_stream
//
// 8N1 UART receiver with an AXI4-Stream style output register. The serial
// line is synchronized, each frame is sampled at bit centres, and every good
// byte is presented on a single-entry valid/ready output register. Reception
// never waits for the consumer: a byte that completes while the previous one
// is still unaccepted is dropped and flagged.
//
// Parameters
//   CLK_FREQ       aclk frequency in Hz
//   BAUD_RATE      serial bit rate in baud (CLK_FREQ/BAUD_RATE must be >= 4)
//
// Ports
//   aclk           clock, all logic on the rising edge
//   aresetn        asynchronous active-low reset
//   rxd            asynchronous serial input, idle high
//   m_axis_tvalid  received byte available
//   m_axis_tready  consumer accepts the byte
//   m_axis_tdata   received byte
//   frame_err      one-cycle pulse when a stop bit samples low
//   overrun        one-cycle pulse when a completed byte is dropped
// -----------------------------------------------------------------------------
module uart_rx_stream #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       rxd,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    // Half a bit period lands the start-bit sample in the middle of the bit;
    // full periods after that keep every later sample centred.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    generate
        if (BAUD_DIV < 4) begin : gBaudCheck
            $error("uart_rx_stream: CLK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchronizer and start-detect qualification
    logic             rxdMeta_q;
    logic             line_q;
    logic [1:0]       syncFill_q;
    logic             armed_q;

    // Receive FSM
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]       bitIdx_q,   bitIdx_d;
    logic [7:0]       shift_q,    shift_d;
    logic             waitIdle_q, waitIdle_d;
    logic             byteDone;
    logic             stopBad;

    // Output register and status pulses
    logic             tvalid_q,   tvalid_d;
    logic [7:0]       tdata_q,    tdata_d;
    logic             frameErr_q, frameErr_d;
    logic             overrun_q,  overrun_d;

    // Two-flop synchronizer. syncFill_q marks when line_q holds a real sample
    // of rxd rather than its reset value; only then can the receiver arm,
    // and it arms on the first high line so that a line held low through
    // reset release is not mistaken for a start edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rxdMeta_q  <= 1'b1;
            line_q     <= 1'b1;
            syncFill_q <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            rxdMeta_q  <= rxd;
            line_q     <= rxdMeta_q;
            syncFill_q <= {syncFill_q[0], 1'b1};
            if (syncFill_q[1] && line_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Receive FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= 3'd0;
            shift_q    <= 8'h00;
            waitIdle_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            waitIdle_q <= waitIdle_d;
        end
    end

    // Receive FSM next state. waitIdle_q is the post-framing-error substate of
    // STOP: the counter is ignored and the FSM just waits for the line to
    // return high before looking for another start bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        waitIdle_d = waitIdle_q;
        byteDone   = 1'b0;
        stopBad    = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && !line_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end

            START: begin
                if (cnt_q == '0) begin
                    if (line_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        cnt_d    = FULL_LOAD;
                        bitIdx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    shift_d  = {line_q, shift_q[7:1]};
                    cnt_d    = FULL_LOAD;
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            STOP: begin
                if (waitIdle_q) begin
                    if (line_q) begin
                        waitIdle_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (cnt_q == '0) begin
                    if (line_q) begin
                        byteDone = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        stopBad    = 1'b1;
                        waitIdle_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register next state. A completed byte loads whenever the
    // register is empty or being drained this cycle; otherwise it is lost
    // and flagged, and the held byte stays untouched.
    always_comb begin
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        frameErr_d = stopBad;
        overrun_d  = 1'b0;

        if (byteDone) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = shift_q;
                tvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Output register and status pulse flops
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid_q   <= 1'b0;
            tdata_q    <= 8'h00;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign frame_err     = frameErr_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_stream
//
// Testbench for uart_rx_stream at 100 MHz / 1 Mbaud (100 clocks per bit).
// Single frames come from a vector table; back-to-back, glitch, overrun,
// simultaneous load/handshake and mid-frame reset are hand-written sequences.
// A negedge monitor collects accepted beats and counts status pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx_stream;

    timeunit 1ns;
    timeprecision 1ps;

    localparam int CLK_FREQ  = 100_000_000;
    localparam int BAUD_RATE = 1_000_000;
    localparam int BIT_CYC   = 100;
    localparam int LATENCY   = BIT_CYC / 2 + 9 * BIT_CYC + 1;

    logic       aclk          = 1'b0;
    logic       aresetn       = 1'b0;
    logic       rxd           = 1'b1;
    logic       m_axis_tready = 1'b0;
    logic       m_axis_tvalid;
    logic [7:0] m_axis_tdata;
    logic       frame_err;
    logic       overrun;

    uart_rx_stream #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .rxd          (rxd),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 aclk = ~aclk;

    int cycleNo = 0;
    always @(posedge aclk) cycleNo++;

    // Monitor: accepted beats, pulse counts and the cycle of each tvalid rise
    logic [7:0] beatQ[$];
    int         frameErrCnt = 0;
    int         overrunCnt  = 0;
    int         bothCnt     = 0;
    int         riseCycle   = -1;
    logic       prevValid   = 1'b0;

    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) beatQ.push_back(m_axis_tdata);
        if (frame_err) frameErrCnt++;
        if (overrun) overrunCnt++;
        if (frame_err && overrun) bothCnt++;
        if (m_axis_tvalid && !prevValid) riseCycle = cycleNo;
        prevValid = m_axis_tvalid;
    end

    int checks = 0;
    int fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] beatAt(input int i);
        return (i < beatQ.size()) ? {24'h0, beatQ[i]} : 32'hFFFF_FFFF;
    endfunction

    // Inputs change 2 ns after a rising edge, well clear of both edges
    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        rxd = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            tick(BIT_CYC);
        end
        rxd = stopBit;
        tick(BIT_CYC);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         expBeats;
        logic [7:0] expData;
        int         expFrameErr;
    } vec_t;

    vec_t vecs[6];

    task automatic applyStimulus(input vec_t v);
        sendFrame(v.data, v.stopBit);
        tick(3 * BIT_CYC);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fe0, ov0, startCycle;

        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
        vecs[2] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[5] = '{8'hC3, 1'b0, 0, 8'h00, 1};

        // Reset values
        aresetn = 1'b0;
        tick(3);
        checkOutput("reset tvalid", m_axis_tvalid, 0);
        checkOutput("reset tdata", m_axis_tdata, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset overrun", overrun, 0);
        aresetn = 1'b1;
        tick(10);

        // Latency of 0xA5, measured from the synchronized start edge
        m_axis_tready = 1'b1;
        beatQ.delete();
        fe0 = frameErrCnt; ov0 = overrunCnt;
        riseCycle  = -1;
        startCycle = cycleNo;
        sendFrame(8'hA5, 1'b1);
        tick(BIT_CYC);
        checkOutput("latency", riseCycle - (startCycle + 2), LATENCY);
        checkOutput("A5 beats", beatQ.size(), 1);
        checkOutput("A5 data", beatAt(0), 32'hA5);
        checkOutput("A5 flags", (frameErrCnt - fe0) + (overrunCnt - ov0), 0);

        // Table of single frames, tready high
        for (int i = 0; i < 6; i++) begin
            beatQ.delete();
            fe0 = frameErrCnt; ov0 = overrunCnt;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d beats", i), beatQ.size(), vecs[i].expBeats);
            if (vecs[i].expBeats > 0)
                checkOutput($sformatf("vec%0d data", i), beatAt(0), {24'h0, vecs[i].expData});
            checkOutput($sformatf("vec%0d frame_err", i), frameErrCnt - fe0, vecs[i].expFrameErr);
            checkOutput($sformatf("vec%0d overrun", i), overrunCnt - ov0, 0);
            checkOutput($sformatf("vec%0d tvalid", i), m_axis_tvalid, 0);
        end

        // Back-to-back frames with no idle time
        beatQ.delete();
        fe0 = frameErrCnt; ov0 = overrunCnt;
        sendFrame(8'h00, 1'b1);
        sendFrame(8'hFF, 1'b1);
        sendFrame(8'h55, 1'b1);
        tick(3 * BIT_CYC);
        checkOutput("b2b beats", beatQ.size(), 3);
        checkOutput("b2b beat0", beatAt(0), 32'h00);
        checkOutput("b2b beat1", beatAt(1), 32'hFF);
        checkOutput("b2b beat2", beatAt(2), 32'h55);
        checkOutput("b2b flags", (frameErrCnt - fe0) + (overrunCnt - ov0), 0);

        // 30-cycle glitch is rejected, following frame still received
        beatQ.delete();
        fe0 = frameErrCnt; ov0 = overrunCnt;
        rxd = 1'b0;
        tick(30);
        rxd = 1'b1;
        tick(3 * BIT_CYC);
        checkOutput("glitch beats", beatQ.size(), 0);
        checkOutput("glitch tvalid", m_axis_tvalid, 0);
        checkOutput("glitch flags", (frameErrCnt - fe0) + (overrunCnt - ov0), 0);
        sendFrame(8'h96, 1'b1);
        tick(3 * BIT_CYC);
        checkOutput("post-glitch beats", beatQ.size(), 1);
        checkOutput("post-glitch data", beatAt(0), 32'h96);

        // Overrun: second byte dropped while the first is held
        m_axis_tready = 1'b0;
        beatQ.delete();
        fe0 = frameErrCnt; ov0 = overrunCnt;
        sendFrame(8'h11, 1'b1);
        sendFrame(8'h22, 1'b1);
        tick(3 * BIT_CYC);
        checkOutput("ovr beats", beatQ.size(), 0);
        checkOutput("ovr tvalid", m_axis_tvalid, 1);
        checkOutput("ovr tdata", m_axis_tdata, 32'h11);
        checkOutput("ovr count", overrunCnt - ov0, 1);
        checkOutput("ovr frame_err", frameErrCnt - fe0, 0);
        m_axis_tready = 1'b1;
        tick(3);
        m_axis_tready = 1'b0;
        checkOutput("ovr drain beats", beatQ.size(), 1);
        checkOutput("ovr drain data", beatAt(0), 32'h11);
        checkOutput("ovr drain tvalid", m_axis_tvalid, 0);

        // New byte loads in the same cycle as the handshake of the old one
        beatQ.delete();
        sendFrame(8'h33, 1'b1);
        tick(2 * BIT_CYC);
        ov0 = overrunCnt;
        fork
            sendFrame(8'h44, 1'b1);
            begin
                tick(LATENCY + 1);
                m_axis_tready = 1'b1;
                tick(1);
                m_axis_tready = 1'b0;
            end
        join
        tick(2 * BIT_CYC);
        checkOutput("same-cycle beats", beatQ.size(), 1);
        checkOutput("same-cycle beat0", beatAt(0), 32'h33);
        checkOutput("same-cycle tvalid", m_axis_tvalid, 1);
        checkOutput("same-cycle tdata", m_axis_tdata, 32'h44);
        checkOutput("same-cycle overrun", overrunCnt - ov0, 0);
        m_axis_tready = 1'b1;
        tick(3);
        checkOutput("same-cycle drain", beatAt(1), 32'h44);

        // Reset in the 4th data bit of 0x7E, line held low across release
        beatQ.delete();
        fe0 = frameErrCnt; ov0 = overrunCnt;
        rxd = 1'b0;
        tick(BIT_CYC);
        rxd = 1'b0; tick(BIT_CYC);
        rxd = 1'b1; tick(BIT_CYC);
        rxd = 1'b1; tick(BIT_CYC);
        rxd = 1'b1; tick(BIT_CYC / 2);
        aresetn = 1'b0;
        rxd     = 1'b0;
        tick(2);
        checkOutput("midrst tvalid", m_axis_tvalid, 0);
        checkOutput("midrst tdata", m_axis_tdata, 0);
        checkOutput("midrst frame_err", frame_err, 0);
        checkOutput("midrst overrun", overrun, 0);
        aresetn = 1'b1;
        tick(3 * BIT_CYC);
        rxd = 1'b1;
        tick(2 * BIT_CYC);
        checkOutput("midrst beats", beatQ.size(), 0);
        checkOutput("midrst flags", (frameErrCnt - fe0) + (overrunCnt - ov0), 0);
        sendFrame(8'h42, 1'b1);
        tick(3 * BIT_CYC);
        checkOutput("post-reset beats", beatQ.size(), 1);
        checkOutput("post-reset data", beatAt(0), 32'h42);

        checkOutput("frame_err with overrun", bothCnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_stream.md
UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, aclk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, serial bit rate in baud.
REQ-003 The block SHALL derive BAUD_DIV = CLK_FREQ/BAUD_RATE by integer division, and elaboration SHALL fail if BAUD_DIV < 4.
REQ-004 The block SHALL have port aclk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port m_axis_tvalid, output, 1 bit: received byte available.
REQ-008 The block SHALL have port m_axis_tready, input, 1 bit: consumer accepts byte.
REQ-009 The block SHALL have port m_axis_tdata, output, 8 bits: received byte.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronized value.
REQ-013 The FSM SHALL have exactly four states, IDLE, START, DATA and STOP, plus a WAIT_IDLE substate of STOP used after a framing error.
REQ-014 IDLE: when line = 0, the FSM SHALL go to START and load the bit counter with BAUD_DIV/2-1.
REQ-015 START: when the counter reaches 0, the FSM SHALL sample line; 1 -> glitch, return to IDLE with no output; 0 -> go to DATA and load BAUD_DIV-1.
REQ-016 DATA: each time the counter reaches 0, the FSM SHALL sample one bit into a shift register LSB-first and reload BAUD_DIV-1; after the 8th bit it SHALL go to STOP.
REQ-017 STOP: when the counter reaches 0, the FSM SHALL sample line; 1 -> byte valid, go to IDLE the next cycle, so a back-to-back start bit is detected.
REQ-018 A stop sample of 0 SHALL pulse frame_err for 1 cycle, discard the byte, and hold in WAIT_IDLE until line = 1, then return to IDLE.
REQ-019 A valid byte SHALL be loaded into the output register, and m_axis_tvalid SHALL assert in the cycle after the stop-bit sample.
REQ-020 Latency from the first line = 0 cycle to the m_axis_tvalid rise SHALL be BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles (excluding the 2 synchronizer cycles).
REQ-021 m_axis_tvalid SHALL stay high, with m_axis_tdata stable, until a cycle with m_axis_tvalid & m_axis_tready; after that cycle it SHALL deassert unless a new byte loads in the same cycle.
REQ-022 A new valid byte arriving while m_axis_tvalid=1 and m_axis_tready=0 SHALL be dropped with a 1-cycle overrun pulse; the held byte SHALL be kept.
REQ-023 A new valid byte arriving in the same cycle as a handshake SHALL be loaded with m_axis_tvalid staying 1 and no overrun.
REQ-024 Reception SHALL never stall on m_axis_tready; the FSM SHALL run independently of the output register.
REQ-025 frame_err and overrun SHALL never assert in the same cycle for the same frame.

Reset
REQ-026 While aresetn=0: FSM = IDLE, counters = 0, synchronizer = 1, m_axis_tvalid = 0, m_axis_tdata = 0x00, frame_err = 0, overrun = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output; after release, a line still low SHALL be treated as a new start edge only after it is first seen high.
REQ-028 Release of aresetn SHALL be usable asynchronously; the first FSM transition SHALL occur no earlier than the 2nd aclk edge after release.

Verification (CLK_FREQ=100e6, BAUD_RATE=1e6, BAUD_DIV=100)
REQ-029 The bench SHALL cover: frame 0xA5 with tready=1 -> one beat of tdata=0xA5, tvalid rising 951 cycles after the synchronized start edge, no flags.
REQ-030 The bench SHALL cover: frames 0x00, 0xFF, 0x55 back-to-back with zero idle, tready=1 -> three beats in order, no flags.
REQ-031 The bench SHALL cover: a 30-cycle low glitch on rxd -> no beat, FSM back in IDLE, no flags.
REQ-032 The bench SHALL cover: frame 0x3C with stop bit 0, then line high -> frame_err pulses once, no beat; a following frame 0x81 is received correctly.
REQ-033 The bench SHALL cover: frames 0x11 then 0x22 with tready=0 throughout -> tdata holds 0x11, overrun pulses once; after tready=1, a single beat of 0x11.
REQ-034 The bench SHALL cover: aresetn pulsed low at the 4th data bit of 0x7E -> outputs at reset values, no beat; the next frame 0x42 is received correctly.
